fifo_read_packer: RTL

Downstream stage of the team's dual-clock FIFO, sitting entirely in the read-clock domain. Pops D_SIZE-bit entries from the FIFO read port and packs WORDS consecutive entries into one wide word. Presents the wide word on a valid/ready stream interface. A FLUSH input forces out a partially filled word, with a per-lane keep mask.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_read_packer_if.sv | 29 ++
 rtl/fifo_lane_demux.sv | 18 +
 rtl/fifo_read_packer.sv | 106 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the read-side FIFO packer.
package fifo_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  localparam int DEFAULT_D_SIZE = 8;

  // Thermometer keep mask, one lane at a time: lanes 0..n-1 are kept.
  function automatic logic keep_lane(input int lane, input int n);
    return lane < n;
  endfunction

endpackage

// File: rtl/fifo_read_packer_if.sv
// FIFO read port plus packed-word valid/ready stream for fifo_read_packer.
interface fifo_read_packer_if
  import fifo_pkg::*;
#(
  parameter int D_SIZE = DEFAULT_D_SIZE,
  parameter int WORDS  = 4
);
  localparam int O_SIZE = D_SIZE * WORDS;

  logic [D_SIZE-1:0] R_DATA;
  logic              EMPTY;
  logic              R_INC;
  logic              FLUSH;
  logic [O_SIZE-1:0] OUT_DATA;
  logic [WORDS-1:0]  OUT_KEEP;
  logic              OUT_VALID;
  logic              OUT_READY;

  modport master (
    input  R_DATA, EMPTY, FLUSH, OUT_READY,
    output R_INC, OUT_DATA, OUT_KEEP, OUT_VALID
  );

  modport slave (
    output R_DATA, EMPTY, FLUSH, OUT_READY,
    input  R_INC, OUT_DATA, OUT_KEEP, OUT_VALID
  );

endinterface

// File: rtl/fifo_lane_demux.sv
// One-hot lane write enable from a lane index; shared with the future unpacker.
module fifo_lane_demux #(
  parameter int WORDS = 4,
  parameter int SEL_W = 2
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [WORDS-1:0] lane_we
);

  always_comb begin
    lane_we = '0;
    for (int k = 0; k < WORDS; k++) begin
      lane_we[k] = en && (sel == SEL_W'(k));
    end
  end

endmodule

// File: rtl/fifo_read_packer.sv
// Pops FWFT FIFO entries and packs WORDS of them into one wide stream word,
// with FLUSH emitting a partial word and a thermometer keep mask.
module fifo_read_packer
  import fifo_pkg::*;
#(
  parameter int D_SIZE = DEFAULT_D_SIZE,
  parameter int WORDS  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  fifo_read_packer_if.master bus
);

  localparam int                CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(WORDS - 1);

  pack_state_t                    state;
  logic [CNT_W-1:0]               cnt;
  logic [WORDS-1:0][D_SIZE-1:0]   lanes;
  logic [WORDS-1:0]               keep;
  logic                           valid;

  logic                           pop;
  logic                           accept;
  logic [CNT_W-1:0]               wr_lane;
  logic [WORDS-1:0]               lane_we;
  logic [WORDS-1:0]               keep_cnt;
  logic [WORDS-1:0]               keep_inc;

  assign accept = valid & bus.OUT_READY;
  assign pop    = !RST && !bus.EMPTY &&
                  ((state == FILL) || ((state == HOLD) && bus.OUT_READY));

  // A pop taken while a word is being accepted starts the next word at lane 0.
  assign wr_lane = (state == HOLD) ? '0 : cnt;

  fifo_lane_demux #(
    .WORDS (WORDS),
    .SEL_W (CNT_W)
  ) u_lane_demux (
    .en      (pop),
    .sel     (wr_lane),
    .lane_we (lane_we)
  );

  always_comb begin
    keep_cnt = '0;
    keep_inc = '0;
    for (int k = 0; k < WORDS; k++) begin
      keep_cnt[k] = keep_lane(k, int'(cnt));
      keep_inc[k] = keep_lane(k, int'(cnt) + 1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FILL;
      cnt   <= '0;
      lanes <= '0;
      keep  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (pop) begin
            for (int k = 0; k < WORDS; k++) begin
              if (lane_we[k]) lanes[k] <= bus.R_DATA;
            end
            keep <= keep_inc;
            if ((cnt == LAST_LANE) || bus.FLUSH) begin
              state <= HOLD;
              cnt   <= '0;
              valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (bus.FLUSH && (cnt != '0)) begin
            // Unused lanes are already zero: they were cleared on the last accept.
            state <= HOLD;
            cnt   <= '0;
            keep  <= keep_cnt;
            valid <= 1'b1;
          end
        end
        HOLD: begin
          if (accept) begin
            state <= FILL;
            valid <= 1'b0;
            keep  <= lane_we;
            cnt   <= pop ? CNT_W'(1) : '0;
            for (int k = 0; k < WORDS; k++) begin
              lanes[k] <= lane_we[k] ? bus.R_DATA : '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.R_INC     = pop;
  assign bus.OUT_DATA  = lanes;
  assign bus.OUT_KEEP  = keep;
  assign bus.OUT_VALID = valid;

endmodule
